// File: rtl/corr_window_search.sv
// corr_window_search: raster sweep of scorer start offsets over a window, tracking the best score.
// Define CORR_SEARCH_TIMEOUT_EN to add a WAIT watchdog that skips a candidate and sets sticky oTimeout.

module corr_window_search #(
   parameter int COORD_W = 13,
   parameter int SCORE_W = 32,
   parameter int X_MIN   = 0,
   parameter int X_MAX   = 64,
   parameter int Y_MIN   = 0,
   parameter int Y_MAX   = 48,
   parameter int STEP    = 4,
   parameter int GUARD   = 2,
   parameter int SETTLE  = 1
`ifdef CORR_SEARCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 65535
`endif
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iStart,
   input  logic               iDone,
   input  logic [SCORE_W-1:0] iScore,
   output logic [COORD_W-1:0] oXcand,
   output logic [COORD_W-1:0] oYcand,
   output logic               oBusy,
   output logic               oDone,
   output logic [COORD_W-1:0] oBestX,
   output logic [COORD_W-1:0] oBestY,
   output logic [SCORE_W-1:0] oBestScore,
   output logic [15:0]        oCandCount
`ifdef CORR_SEARCH_TIMEOUT_EN
   ,
   output logic               oTimeout
`endif
);

   localparam int CW1 = COORD_W + 1;
   localparam logic [CW1-1:0]     STEP_W  = CW1'(STEP);
   localparam logic [CW1-1:0]     X_MAX_W = CW1'(X_MAX);
   localparam logic [CW1-1:0]     Y_MAX_W = CW1'(Y_MAX);
   localparam logic [COORD_W-1:0] X_MIN_C = COORD_W'(X_MIN);
   localparam logic [COORD_W-1:0] Y_MIN_C = COORD_W'(Y_MIN);
   localparam logic [15:0] GUARD_LAST  = (GUARD > 0)  ? 16'(GUARD - 1)  : 16'd0;
   localparam logic [15:0] SETTLE_LAST = (SETTLE > 0) ? 16'(SETTLE - 1) : 16'd0;
`ifdef CORR_SEARCH_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_GUARD, S_WAIT, S_SETTLE, S_COMPARE, S_ADVANCE, S_FINISH
   } state_t;

   state_t state, state_nxt;

   logic [COORD_W-1:0] x_cur, y_cur, best_x, best_y;
   logic [SCORE_W-1:0] best_score;
   logic [15:0]        count;
   logic [15:0]        tmr;
   logic [CW1-1:0]     x_next, y_next;
   logic               x_fits, y_fits;
   logic               wait_expired;

   // One extra bit so a window edge near the top of the coordinate range cannot wrap.
   assign x_next = {1'b0, x_cur} + STEP_W;
   assign y_next = {1'b0, y_cur} + STEP_W;
   assign x_fits = (x_next <= X_MAX_W);
   assign y_fits = (y_next <= Y_MAX_W);

`ifdef CORR_SEARCH_TIMEOUT_EN
   assign wait_expired = (tmr == TO_LAST);
`else
   assign wait_expired = 1'b0;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (iStart) state_nxt = S_LAUNCH;
         S_LAUNCH:  state_nxt = (GUARD == 0) ? S_WAIT : S_GUARD;
         S_GUARD:   if (tmr == GUARD_LAST) state_nxt = S_WAIT;
         S_WAIT: begin
            if (iDone)             state_nxt = (SETTLE == 0) ? S_COMPARE : S_SETTLE;
            else if (wait_expired) state_nxt = S_ADVANCE;
         end
         S_SETTLE:  if (tmr == SETTLE_LAST) state_nxt = S_COMPARE;
         S_COMPARE: state_nxt = S_ADVANCE;
         S_ADVANCE: state_nxt = (x_fits || y_fits) ? S_LAUNCH : S_FINISH;
         S_FINISH:  state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // tmr counts cycles spent in the current state; shared by guard, settle and watchdog.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)                 tmr <= '0;
      else if (state_nxt != state) tmr <= '0;
      else                         tmr <= tmr + 16'd1;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         x_cur      <= '0;
         y_cur      <= '0;
         best_x     <= '0;
         best_y     <= '0;
         best_score <= '0;
         count      <= '0;
         oXcand     <= '0;
         oYcand     <= '0;
         oBestX     <= '0;
         oBestY     <= '0;
         oBestScore <= '0;
         oCandCount <= '0;
      end else begin
         case (state)
            S_IDLE: if (iStart) begin
               x_cur      <= X_MIN_C;
               y_cur      <= Y_MIN_C;
               best_x     <= X_MIN_C;
               best_y     <= Y_MIN_C;
               best_score <= '0;
               count      <= '0;
            end
            S_LAUNCH: begin
               oXcand <= x_cur;
               oYcand <= y_cur;
            end
            S_COMPARE: begin
               count <= count + 16'd1;
               // Strict compare: on a tie the earlier raster candidate is kept.
               if (iScore > best_score) begin
                  best_score <= iScore;
                  best_x     <= x_cur;
                  best_y     <= y_cur;
               end
            end
            S_ADVANCE: begin
               if (x_fits) begin
                  x_cur <= x_next[COORD_W-1:0];
               end else if (y_fits) begin
                  x_cur <= X_MIN_C;
                  y_cur <= y_next[COORD_W-1:0];
               end
            end
            S_FINISH: begin
               oBestX     <= best_x;
               oBestY     <= best_y;
               oBestScore <= best_score;
               oCandCount <= count;
            end
            default: ;
         endcase
      end
   end

`ifdef CORR_SEARCH_TIMEOUT_EN
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)                                        oTimeout <= 1'b0;
      else if (state == S_IDLE && iStart)                 oTimeout <= 1'b0;
      else if (state == S_WAIT && !iDone && wait_expired) oTimeout <= 1'b1;
   end
`endif

   assign oBusy = (state != S_IDLE);
   assign oDone = (state == S_FINISH);

endmodule

// File: tb/tb_corr_window_search.sv
// Directed bench for corr_window_search: 9x5 window at step 4 with a behavioural scorer,
// plus a second instance with X_MAX=7 to check raster clipping.

module tb_corr_window_search;

   logic        iCLK, iRST_N;
   logic        start1, done1, busy1, dn1;
   logic [31:0] score1, bs1;
   logic [12:0] xc1, yc1, bx1, by1;
   logic [15:0] cc1;
   logic        start2, done2, busy2, dn2;
   logic [31:0] score2, bs2;
   logic [12:0] xc2, yc2, bx2, by2;
   logic [15:0] cc2;
`ifdef CORR_SEARCH_TIMEOUT_EN
   logic        to1, to2;
`endif

   int n_vec = 0;
   int n_err = 0;
   int mode  = 0;
   int scen  = 0;
   int dpulses = 0;
   bit rec1_en = 0, rec2_en = 0;
   logic [25:0] rec1[$];
   logic [25:0] rec2[$];

   corr_window_search #(.X_MIN(0), .X_MAX(8), .Y_MIN(0), .Y_MAX(4), .STEP(4), .GUARD(2), .SETTLE(1)
`ifdef CORR_SEARCH_TIMEOUT_EN
      , .TIMEOUT(100)
`endif
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iStart(start1), .iDone(done1), .iScore(score1),
      .oXcand(xc1), .oYcand(yc1), .oBusy(busy1), .oDone(dn1),
      .oBestX(bx1), .oBestY(by1), .oBestScore(bs1), .oCandCount(cc1)
`ifdef CORR_SEARCH_TIMEOUT_EN
      , .oTimeout(to1)
`endif
   );

   corr_window_search #(.X_MIN(0), .X_MAX(7), .Y_MIN(0), .Y_MAX(4), .STEP(4), .GUARD(2), .SETTLE(1)
`ifdef CORR_SEARCH_TIMEOUT_EN
      , .TIMEOUT(100)
`endif
   ) dut2 (
      .iCLK(iCLK), .iRST_N(iRST_N), .iStart(start2), .iDone(done2), .iScore(score2),
      .oXcand(xc2), .oYcand(yc2), .oBusy(busy2), .oDone(dn2),
      .oBestX(bx2), .oBestY(by2), .oBestScore(bs2), .oCandCount(cc2)
`ifdef CORR_SEARCH_TIMEOUT_EN
      , .oTimeout(to2)
`endif
   );

   initial begin
      iCLK = 0;
      forever #10 iCLK = ~iCLK;
   end

   function automatic logic [31:0] score_of(input int s, input logic [12:0] x, input logic [12:0] y);
      case (s)
         0:       return (x == 4 && y == 4) ? 32'd900 : 32'd100;
         1:       return ((x == 0 || x == 8) && y == 0) ? 32'd500 : 32'd200;
         default: return 32'd0;
      endcase
   endfunction

   // Scorer model: finishes 4 cycles after the start coordinates change.
   // mode 1 holds a stale done high with a stale score until just before the correct sample point.
   // mode 2 never finishes at (4,0).
   initial begin
      int age;
      logic [12:0] px, py;
      logic [31:0] sc;
      age = 0; px = 0; py = 0; done1 = 0; score1 = 0;
      forever begin
         @(negedge iCLK);
         if (xc1 !== px || yc1 !== py) begin
            age = 0;
            if (rec1_en) rec1.push_back({xc1, yc1});
         end else if (age < 1000) age++;
         px = xc1; py = yc1;
         sc = score_of(scen, xc1, yc1);
         case (mode)
            1:       begin done1 = 1'b1; score1 = (age <= 3) ? 32'd5000 : sc; end
            2:       begin done1 = !(xc1 == 4 && yc1 == 0) && (age >= 4); score1 = sc; end
            default: begin done1 = (age >= 4); score1 = sc; end
         endcase
      end
   end

   // Second scorer is always done; its score follows the current coordinates.
   initial begin
      logic [12:0] px, py;
      px = 0; py = 0; done2 = 1; score2 = 0;
      forever begin
         @(negedge iCLK);
         if ((xc2 !== px || yc2 !== py) && rec2_en) rec2.push_back({xc2, yc2});
         px = xc2; py = yc2;
         score2 = 32'(xc2) * 10 + 32'(yc2) + 1;
      end
   end

   initial begin
      forever begin
         @(negedge iCLK);
         if (dn1 === 1'b1) dpulses++;
      end
   end

   task automatic pulse1();
      @(negedge iCLK); start1 = 1;
      @(negedge iCLK); start1 = 0;
   endtask

   task automatic pulse2();
      @(negedge iCLK); start2 = 1;
      @(negedge iCLK); start2 = 0;
   endtask

   task automatic wait_done1(input int maxc, output bit ok);
      int c = 0;
      while (dn1 !== 1'b1 && c < maxc) begin @(negedge iCLK); c++; end
      ok = (dn1 === 1'b1);
   endtask

   task automatic wait_done2(input int maxc, output bit ok);
      int c = 0;
      while (dn2 !== 1'b1 && c < maxc) begin @(negedge iCLK); c++; end
      ok = (dn2 === 1'b1);
   endtask

   task automatic wait_coord1(input logic [12:0] x, input logic [12:0] y, input int maxc, output bit ok);
      int c = 0;
      while (!(xc1 === x && yc1 === y) && c < maxc) begin @(negedge iCLK); c++; end
      ok = (xc1 === x && yc1 === y);
   endtask

   task automatic test_reset();
      iRST_N = 0; start1 = 0; start2 = 0;
      repeat (3) @(negedge iCLK);
      n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy1); end
      n_vec++; if (dn1 !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", dn1); end
      n_vec++; if (xc1 !== 13'd0 || yc1 !== 13'd0) begin n_err++; $display("FAIL reset_cand got %0d,%0d want 0,0", xc1, yc1); end
      n_vec++; if (bx1 !== 13'd0 || by1 !== 13'd0) begin n_err++; $display("FAIL reset_best got %0d,%0d want 0,0", bx1, by1); end
      n_vec++; if (bs1 !== 32'd0) begin n_err++; $display("FAIL reset_score got %0d want 0", bs1); end
      n_vec++; if (cc1 !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", cc1); end
      iRST_N = 1;
      repeat (8) @(negedge iCLK);
      n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy1); end
   endtask

   task automatic test_peak();
      bit ok;
      mode = 0; scen = 0; dpulses = 0;
      pulse1();
      n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL peak_busy got %b want 1", busy1); end
      wait_done1(500, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL peak_timeout got no oDone want oDone"); end
      @(negedge iCLK);
      n_vec++; if (bx1 !== 13'd4 || by1 !== 13'd4) begin n_err++; $display("FAIL peak_xy got %0d,%0d want 4,4", bx1, by1); end
      n_vec++; if (bs1 !== 32'd900) begin n_err++; $display("FAIL peak_score got %0d want 900", bs1); end
      n_vec++; if (cc1 !== 16'd6) begin n_err++; $display("FAIL peak_count got %0d want 6", cc1); end
      n_vec++; if (dn1 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL peak_after got done=%b busy=%b want 0,0", dn1, busy1); end
      repeat (5) @(negedge iCLK);
      n_vec++; if (dpulses != 1) begin n_err++; $display("FAIL peak_pulses got %0d want 1", dpulses); end
   endtask

   task automatic test_tie_order();
      bit ok;
      logic [25:0] e;
      int ox[6] = '{0, 4, 8, 0, 4, 8};
      int oy[6] = '{0, 0, 0, 4, 4, 4};
      mode = 0; scen = 1;
      rec1.delete(); rec1_en = 1;
      pulse1();
      wait_done1(500, ok);
      rec1_en = 0;
      n_vec++; if (!ok) begin n_err++; $display("FAIL tie_timeout got no oDone want oDone"); end
      @(negedge iCLK);
      n_vec++; if (bx1 !== 13'd0 || by1 !== 13'd0) begin n_err++; $display("FAIL tie_xy got %0d,%0d want 0,0", bx1, by1); end
      n_vec++; if (bs1 !== 32'd500) begin n_err++; $display("FAIL tie_score got %0d want 500", bs1); end
      n_vec++; if (rec1.size() != 6) begin n_err++; $display("FAIL order_len got %0d want 6", rec1.size()); end
      for (int i = 0; i < 6 && i < rec1.size(); i++) begin
         e = rec1[i];
         n_vec++;
         if (e[25:13] !== 13'(ox[i]) || e[12:0] !== 13'(oy[i])) begin
            n_err++; $display("FAIL order_%0d got %0d,%0d want %0d,%0d", i, e[25:13], e[12:0], ox[i], oy[i]);
         end
      end
   endtask

   task automatic test_xmax7();
      bit ok;
      logic [25:0] e;
      int ox[4] = '{0, 4, 0, 4};
      int oy[4] = '{0, 0, 4, 4};
      pulse2();
      wait_done2(500, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL x7_first_timeout got no oDone want oDone"); end
      rec2.delete(); rec2_en = 1;
      pulse2();
      wait_done2(500, ok);
      rec2_en = 0;
      n_vec++; if (!ok) begin n_err++; $display("FAIL x7_timeout got no oDone want oDone"); end
      @(negedge iCLK);
      n_vec++; if (cc2 !== 16'd4) begin n_err++; $display("FAIL x7_count got %0d want 4", cc2); end
      n_vec++; if (bx2 !== 13'd4 || by2 !== 13'd4 || bs2 !== 32'd45) begin
         n_err++; $display("FAIL x7_best got %0d,%0d,%0d want 4,4,45", bx2, by2, bs2);
      end
      n_vec++; if (rec2.size() != 4) begin n_err++; $display("FAIL x7_len got %0d want 4", rec2.size()); end
      for (int i = 0; i < 4 && i < rec2.size(); i++) begin
         e = rec2[i];
         n_vec++;
         if (e[25:13] !== 13'(ox[i]) || e[12:0] !== 13'(oy[i])) begin
            n_err++; $display("FAIL x7_order_%0d got %0d,%0d want %0d,%0d", i, e[25:13], e[12:0], ox[i], oy[i]);
         end
      end
   endtask

   task automatic test_stale_done();
      bit ok;
      mode = 1; scen = 0;
      pulse1();
      wait_done1(500, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL stale_timeout got no oDone want oDone"); end
      @(negedge iCLK);
      n_vec++; if (bs1 !== 32'd900) begin n_err++; $display("FAIL stale_score got %0d want 900", bs1); end
      n_vec++; if (bx1 !== 13'd4 || by1 !== 13'd4 || cc1 !== 16'd6) begin
         n_err++; $display("FAIL stale_best got %0d,%0d,%0d want 4,4,6", bx1, by1, cc1);
      end
      mode = 0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [25:0] e;
      int ox[5] = '{4, 8, 0, 4, 8};
      int oy[5] = '{0, 0, 4, 4, 4};
      mode = 0; scen = 0;
      pulse1();
      wait_coord1(13'd8, 13'd0, 200, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL mid_reach got %0d,%0d want 8,0", xc1, yc1); end
      repeat (2) @(negedge iCLK);
      iRST_N = 0;
      #1;
      n_vec++; if (busy1 !== 1'b0 || dn1 !== 1'b0) begin n_err++; $display("FAIL mid_ctl got busy=%b done=%b want 0,0", busy1, dn1); end
      n_vec++; if (xc1 !== 13'd0 || yc1 !== 13'd0) begin n_err++; $display("FAIL mid_cand got %0d,%0d want 0,0", xc1, yc1); end
      n_vec++; if (bs1 !== 32'd0 || bx1 !== 13'd0 || by1 !== 13'd0 || cc1 !== 16'd0) begin
         n_err++; $display("FAIL mid_best got %0d,%0d,%0d,%0d want 0,0,0,0", bx1, by1, bs1, cc1);
      end
      repeat (2) @(negedge iCLK);
      iRST_N = 1;
      @(negedge iCLK);
      rec1.delete(); rec1_en = 1;
      pulse1();
      wait_coord1(13'd0, 13'd4, 200, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL mid_reach2 got %0d,%0d want 0,4", xc1, yc1); end
      pulse1();
      wait_done1(500, ok);
      rec1_en = 0;
      n_vec++; if (!ok) begin n_err++; $display("FAIL mid_timeout got no oDone want oDone"); end
      @(negedge iCLK);
      n_vec++; if (bx1 !== 13'd4 || by1 !== 13'd4 || bs1 !== 32'd900 || cc1 !== 16'd6) begin
         n_err++; $display("FAIL mid_result got %0d,%0d,%0d,%0d want 4,4,900,6", bx1, by1, bs1, cc1);
      end
      n_vec++; if (rec1.size() != 5) begin n_err++; $display("FAIL mid_len got %0d want 5", rec1.size()); end
      for (int i = 0; i < 5 && i < rec1.size(); i++) begin
         e = rec1[i];
         n_vec++;
         if (e[25:13] !== 13'(ox[i]) || e[12:0] !== 13'(oy[i])) begin
            n_err++; $display("FAIL mid_order_%0d got %0d,%0d want %0d,%0d", i, e[25:13], e[12:0], ox[i], oy[i]);
         end
      end
   endtask

   task automatic test_zero_and_hold();
      bit ok;
      repeat (10) @(negedge iCLK);
      n_vec++; if (bs1 !== 32'd900 || cc1 !== 16'd6) begin n_err++; $display("FAIL hold got %0d,%0d want 900,6", bs1, cc1); end
      mode = 0; scen = 2;
      pulse1();
      wait_done1(500, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL zero_timeout got no oDone want oDone"); end
      @(negedge iCLK);
      n_vec++; if (bx1 !== 13'd0 || by1 !== 13'd0 || bs1 !== 32'd0 || cc1 !== 16'd6) begin
         n_err++; $display("FAIL zero_result got %0d,%0d,%0d,%0d want 0,0,0,6", bx1, by1, bs1, cc1);
      end
   endtask

`ifdef CORR_SEARCH_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      mode = 2; scen = 0;
      pulse1();
      wait_done1(1000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL to_timeout got no oDone want oDone"); end
      @(negedge iCLK);
      n_vec++; if (cc1 !== 16'd5) begin n_err++; $display("FAIL to_count got %0d want 5", cc1); end
      n_vec++; if (to1 !== 1'b1) begin n_err++; $display("FAIL to_flag got %b want 1", to1); end
      n_vec++; if (bx1 !== 13'd4 || by1 !== 13'd4 || bs1 !== 32'd900) begin
         n_err++; $display("FAIL to_best got %0d,%0d,%0d want 4,4,900", bx1, by1, bs1);
      end
      mode = 0;
      pulse1();
      wait_done1(500, ok);
      @(negedge iCLK);
      n_vec++; if (to1 !== 1'b0 || cc1 !== 16'd6) begin n_err++; $display("FAIL to_clear got %b,%0d want 0,6", to1, cc1); end
   endtask
`endif

   initial begin
      iRST_N = 0; start1 = 0; start2 = 0;
      test_reset();
      test_peak();
      test_tie_order();
      test_xmax7();
      test_stale_done();
      test_reset_mid();
      test_zero_and_hold();
`ifdef CORR_SEARCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/corr_window_search.md
Name: corr_window_search

Overview:
- Sequencer that sits directly downstream of the correlation scorer and also drives its start coordinates.
- Sweeps candidate (X,Y) offsets in raster order over a programmable window.
- For each candidate it waits for the scorer to finish, captures the score, and tracks the running maximum.
- Publishes the best offset and score to the tracking/overlay logic once the sweep ends.

Parameters:
- COORD_W, 13, width of all coordinate ports
- SCORE_W, 32, width of score ports
- X_MIN, 0, first candidate X
- X_MAX, 64, last allowed candidate X (inclusive)
- Y_MIN, 0, first candidate Y
- Y_MAX, 48, last allowed candidate Y (inclusive)
- STEP, 4, candidate increment on both axes, must be >= 1
- GUARD, 2, cycles after a launch during which iDone is ignored
- SETTLE, 1, cycles between accepted iDone and sampling iScore
- TIMEOUT, 65535, watchdog limit in cycles (feature only)

Ports:
- iCLK  in  1  system clock (50 MHz)
- iRST_N  in  1  asynchronous active-low reset
- iStart  in  1  one-cycle pulse; begins a sweep when idle
- iDone  in  1  scorer finished flag
- iScore  in  SCORE_W  scorer final score
- oXcand  out  COORD_W  candidate X start to scorer
- oYcand  out  COORD_W  candidate Y start to scorer
- oBusy  out  1  high from accepted iStart until oDone
- oDone  out  1  one-cycle pulse at sweep end
- oBestX  out  COORD_W  best candidate X of last completed sweep
- oBestY  out  COORD_W  best candidate Y of last completed sweep
- oBestScore  out  SCORE_W  best score of last completed sweep
- oCandCount  out  16  candidates evaluated in last completed sweep

Behaviour:
- Reset (async, iRST_N low): state IDLE; all outputs 0; internal best registers 0; counters 0.
- States: IDLE, LAUNCH, GUARD, WAIT, SETTLE, COMPARE, ADVANCE, FINISH.
- IDLE:
  - on iStart, load X=X_MIN, Y=Y_MIN, running best score=0, best coords=(X_MIN,Y_MIN), count=0, then go to LAUNCH.
  - iStart in any other state is ignored.
- LAUNCH: drive oXcand/oYcand with the new candidate (registered, stable until the next LAUNCH); go to GUARD.
- GUARD: count GUARD cycles ignoring iDone (this masks a stale finished flag left over from the previous candidate); then WAIT. GUARD=0 skips straight to WAIT.
- WAIT: remain until iDone=1; then SETTLE.
- SETTLE: count SETTLE cycles; then COMPARE.
- COMPARE:
  - sample iScore; increment count.
  - if iScore > running best (strictly greater), update best score and coords.
  - ties keep the earlier candidate in raster order.
  - then ADVANCE.
- ADVANCE (X is the inner loop):
  - if X+STEP <= X_MAX: X += STEP, go to LAUNCH.
  - else if Y+STEP <= Y_MAX: X=X_MIN, Y += STEP, go to LAUNCH.
  - else go to FINISH.
  - Comparisons use COORD_W+1 bits so X_MAX near 2^COORD_W-1 cannot wrap.
- FINISH:
  - copy running best and count to oBestX/oBestY/oBestScore/oCandCount.
  - oDone=1 for exactly one cycle; oBusy falls in the same cycle; return to IDLE.
- oBest*/oCandCount change only in FINISH and hold between sweeps.
- oBusy is high in every state except IDLE.
- Single-candidate window (X_MIN=X_MAX, Y_MIN=Y_MAX): exactly one evaluation, count=1.
- Reset mid-sweep: immediate return to IDLE with all outputs 0; the previous published result is lost.
- All-zero scores: best coords=(X_MIN,Y_MIN), best score 0.
- Latency per candidate: 1 (LAUNCH) + GUARD + scorer time + SETTLE + 2 (COMPARE, ADVANCE) cycles.

Optional Feature:
- Macro: CORR_SEARCH_TIMEOUT_EN.
- Defined:
  - a 16-bit watchdog counts cycles spent in WAIT.
  - on reaching TIMEOUT, the candidate is skipped: no compare, count not incremented, go to ADVANCE.
  - extra output oTimeout (1 bit), sticky high from the first timeout until the next accepted iStart; reset 0.
- Undefined: no watchdog and no oTimeout port; WAIT is unbounded.

Test Plan:
- Window X 0..8, Y 0..4, STEP 4; scorer model returns fixed scores, peak 900 at (4,4), others 100 -> oBestX=4, oBestY=4, oBestScore=900, oCandCount=6, single oDone pulse.
- Tie: (0,0) and (8,0) both 500, all others lower -> oBestX=0, oBestY=0 (first wins).
- Candidate order: record oXcand/oYcand at each LAUNCH for X 0..8, Y 0..4, STEP 4 -> sequence (0,0),(4,0),(8,0),(0,4),(4,4),(8,4); X_MAX=7 gives X values 0,4 only.
- Stale iDone held high through GUARD=2 -> not accepted before the guard expires; score sampled SETTLE=1 cycle after the first accepted iDone.
- Assert iRST_N low during the 3rd candidate's WAIT, then restart with iStart -> outputs 0 while in reset; the new sweep gives correct results and iStart while busy is ignored.
- With CORR_SEARCH_TIMEOUT_EN, TIMEOUT=100, scorer never finishes at (4,0) -> (4,0) skipped after 100 cycles, oTimeout=1, oCandCount=5.
